// File: rtl/iic_slave_regport.sv
// rtl/iic_slave_regport.sv - I2C target exposing a 256 x 8 register window on a parallel port
// Optional SCL/SDA glitch filter enabled by defining IIC_SLAVE_GLITCH_FILTER_EN
module iic_slave_regport #(
  parameter logic [6:0] DEV_ADDR = 7'h39
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr,
  output logic       o_reg_rd,
  input  logic [7:0] i_reg_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_IGNORE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte_in;
  logic       byte_done;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       rd_p1_q, rd_p2_q;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i_scl};
      sda_sync_q <= {sda_sync_q[0], i_sda};
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  // A line must disagree with its filtered value for 4 straight clocks to flip it.
  logic       scl_filt_q, sda_filt_q;
  logic [1:0] scl_cnt_q, sda_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= 2'd0;
      sda_cnt_q  <= 2'd0;
    end else begin
      if (scl_sync_q[1] == scl_filt_q) begin
        scl_cnt_q <= 2'd0;
      end else if (scl_cnt_q == 2'd3) begin
        scl_filt_q <= scl_sync_q[1];
        scl_cnt_q  <= 2'd0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 2'd1;
      end
      if (sda_sync_q[1] == sda_filt_q) begin
        sda_cnt_q <= 2'd0;
      end else if (sda_cnt_q == 2'd3) begin
        sda_filt_q <= sda_sync_q[1];
        sda_cnt_q  <= 2'd0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 2'd1;
      end
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      rd_p1_q     <= reg_rd_q;
      rd_p2_q     <= rd_p1_q;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // ACK states use sda_oe_q as their phase: first SCL fall drives, second fall leaves.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_START;
    end else begin
      case (state_q)
        S_START:     if (scl_fall) state_d = S_ADDR;
        S_ADDR:      if (byte_done) state_d = (byte_in[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (scl_fall && sda_oe_q) state_d = rw_q ? S_RDATA : S_SUB;
        S_SUB:       if (byte_done) state_d = S_SUB_ACK;
        S_SUB_ACK:   if (scl_fall && sda_oe_q) state_d = S_WDATA;
        S_WDATA:     if (byte_done) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && sda_oe_q) state_d = S_WDATA;
        S_RDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = S_MACK;
        S_MACK: begin
          if (scl_rise && sda_s) state_d = S_IGNORE;
          else if (scl_fall && mack_q) state_d = S_RDATA;
        end
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    if (stop_det) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
      mack_d    = 1'b0;
    end else if (start_det) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
      mack_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_SUB, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
          end
          if (byte_done && state_q == S_ADDR) rw_d = byte_in[0];
          if (byte_done && state_q == S_SUB) reg_addr_d = byte_in;
          if (byte_done && state_q == S_WDATA) begin
            reg_wdata_d = byte_in;
            reg_wr_d    = 1'b1;
          end
        end
        S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q && state_q == S_ADDR_ACK && rw_q) reg_rd_d = 1'b1;
            if (sda_oe_q && state_q == S_WDATA_ACK) reg_addr_d = reg_addr_q + 8'd1;
          end
        end
        S_RDATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            mack_d    = 1'b0;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
          // Read data lands two clocks after the request; bit 7 goes out immediately.
          if (rd_p2_q) begin
            shift_d  = i_reg_rdata;
            sda_oe_d = ~i_reg_rdata[7];
          end
        end
        S_MACK: begin
          if (scl_rise && !sda_s) begin
            mack_d     = 1'b1;
            reg_addr_d = reg_addr_q + 8'd1;
          end else if (scl_fall && mack_q) begin
            mack_d   = 1'b0;
            reg_rd_d = 1'b1;
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign o_sda_oe    = sda_oe_q;
  assign o_busy      = busy_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_reg_wr    = reg_wr_q;
  assign o_reg_rd    = reg_rd_q;

endmodule
